tristate_bus_arbiter: RTL and testbench
=======================================

// Module: tristate_bus_arbiter
// PURPOSE
//  Parametrised N-channel bus multiplexer built on tristate drivers, with round-robin ownership.
//  Each channel raises req; one owner at a time drives the shared internal bus through its tristate buffer.
//  Ownership is bounded by a burst limit; every hand-over inserts a dead turnaround gap (all drivers high-Z).
//  The bus value is registered out with a valid flag. Sits between local producers and a single shared sink.
// PARAMETERS
//  N_CH        4  number of channels (2..16)
//  WIDTH       8  data width per channel and of shared bus
//  MAX_BURST   4  max consecutive grant cycles while another channel waits (>=1)
//  TURNAROUND  1  idle cycles with all drivers released between owners (1..4)
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  req        in   N_CH           per-channel request, level
//  din        in   N_CH*WIDTH     channel i data at din[i*WIDTH +: WIDTH]
//  gnt        out  N_CH           registered one-hot grant (all zero when no owner)
//  owner      out  $clog2(N_CH)   index of current/last owner
//  bus_valid  out  1              bus_data holds a sampled owner word this cycle
//  bus_data   out  WIDTH          registered copy of shared tristate bus
// BEHAVIOUR
//  - Reset (sync, rst high at edge): state IDLE, gnt=0, all tristate enables off, owner=0, bus_valid=0,
//    bus_data=0, rr pointer=0, burst count=0. Mid-burst reset: gnt drops after that edge, bus floats.
//  - Internal bus: bus_w = 'z unless exactly one enable; enable[i] = gnt[i] (combinational from register).
//  - FSM IDLE: if |req, pick first requesting channel from pointer upward with wrap (N_CH-1 -> 0);
//    gnt/owner load at that edge -> GRANT; burst count=1. req at edge k => gnt high after edge k.
//  - FSM GRANT: each edge with req[owner]=1: bus_data <= bus_w, bus_valid <= 1 (valid one cycle after gnt).
//    Release when req[owner]=0 (that edge: bus_valid<=0, gnt<=0), or burst count==MAX_BURST and any other
//    req high (that edge: last word sampled, gnt<=0). Release -> TURN; pointer <= owner+1 (wrap).
//    Burst count==MAX_BURST with no other req: keep grant, count restarts at 1.
//  - FSM TURN: gnt=0, enables off, bus_valid=0, bus_data holds; after TURNAROUND cycles -> IDLE arbitration
//    (arbitration occurs in the IDLE cycle, so min gap owner->owner = TURNAROUND+1 grant-free edges).
//  - bus_data holds last value whenever bus_valid=0. owner holds last index while gnt=0.
//  - Invariant: gnt is $onehot0 every cycle; never two enables; bus_w never X when gnt!=0.
//  - req changes during TURN/IDLE are sampled only at arbitration; dropped reqs are never granted.
// STRUCTURE
//  - Shared header tristate_arb_defs.vh: FSM state encodings (IDLE/GRANT/TURN), width helper macro.
//  - Sub-module tristate_buf #(WIDTH): y = en ? a : {WIDTH{1'bz}}; instantiated N_CH times via generate.
//  - Round-robin picker: combinational function in top (double-width mask or loop from pointer).
//  - Counters: burst count $clog2(MAX_BURST+1) bits, turnaround count $clog2(TURNAROUND+1) bits.
// TESTING  (N_CH=4, WIDTH=8, MAX_BURST=4, TURNAROUND=1)
//  1 rst held 2 cycles with req=4'b1111 -> gnt=0, bus_valid=0, bus_data=8'h00; release rst -> gnt=4'b0001.
//  2 req=4'b0100, din[2]=8'hA5 3 cycles then drop -> gnt=4'b0100 next edge, bus_data=A5 valid 3 cycles, TURN.
//  3 req=4'b0011 held -> ch0 owns 4 cycles, 1 gap + IDLE cycle, ch1 owns 4, gap, ch0 again (wrap fairness).
//  4 req=4'b0001 alone held 10 cycles -> gnt stays 4'b0001, bus_valid continuous, no turnaround inserted.
//  5 rst pulsed mid-burst on ch3 (din=8'h3C) -> next edge gnt=0, bus_valid=0, bus_data=0, pointer=0.
//  6 random req/din 2000 cycles -> checker: $onehot0(gnt), bus_data==din[owner] of prior cycle, no Z/X when valid.

Source files
------------

// File: rtl/tristate_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter_pkg
//   Shared definitions for the tristate bus arbiter: FSM state encoding and a
//   width helper for channel-index signals.
// -----------------------------------------------------------------------------
package tristate_bus_arbiter_pkg;

    // Arbiter phases: waiting to arbitrate, one channel owns the bus, or the
    // dead gap between owners with all drivers released.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Bits needed to index n channels (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tristate_buf.sv
// -----------------------------------------------------------------------------
// tristate_buf
//   Single tristate driver onto a shared bus.
// Ports:
//   en  in   1      drive enable
//   a   in   WIDTH  value to drive while enabled
//   y   out  WIDTH  bus connection, high-Z while disabled
// -----------------------------------------------------------------------------
module tristate_buf #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    output tri   [WIDTH-1:0] y
);

    assign y = en ? a : {WIDTH{1'bz}};

endmodule

// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//   N-channel round-robin arbiter in front of a shared tristate bus. The owner
//   drives the internal bus through its own tristate buffer; the bus value is
//   registered out with a valid flag. Ownership is capped at MAX_BURST cycles
//   while another channel waits, and every hand-over leaves TURNAROUND cycles
//   with all drivers released before the next arbitration.
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous active-high reset
//   req        in   N_CH           per-channel level request
//   din        in   N_CH*WIDTH     channel i data at din[i*WIDTH +: WIDTH]
//   gnt        out  N_CH           registered one-hot grant, zero when no owner
//   owner      out  idx width      index of current / last owner
//   bus_valid  out  1              bus_data holds a word sampled from the owner
//   bus_data   out  WIDTH          registered copy of the shared bus
// -----------------------------------------------------------------------------
module tristate_bus_arbiter
    import tristate_bus_arbiter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 8,
    parameter int MAX_BURST  = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               req,
    input  logic [N_CH*WIDTH-1:0]         din,
    output logic [N_CH-1:0]               gnt,
    output logic [idx_width(N_CH)-1:0]    owner,
    output logic                          bus_valid,
    output logic [WIDTH-1:0]              bus_data
);

    localparam int OW = idx_width(N_CH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [TW-1:0] TURN_MAX  = TW'(TURNAROUND);

    // ------------------------------------------------------------------
    // Shared tristate bus: each channel's buffer is enabled straight from
    // its registered grant bit, so at most one driver is ever active.
    // ------------------------------------------------------------------
    tri [WIDTH-1:0] bus_w;

    for (genvar i = 0; i < N_CH; i++) begin : g_drv
        tristate_buf #(
            .WIDTH (WIDTH)
        ) u_buf (
            .en (gnt[i]),
            .a  (din[i*WIDTH +: WIDTH]),
            .y  (bus_w)
        );
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Channel after i, wrapping N_CH-1 back to 0 (N_CH need not be 2^k).
    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        return (int'(i) == N_CH - 1) ? '0 : i + OW'(1);
    endfunction

    // First requesting channel at or after pointer p, wrapping around.
    function automatic logic [OW-1:0] rr_pick(input logic [N_CH-1:0] r,
                                              input logic [OW-1:0]   p);
        logic [OW-1:0] pick;
        logic          found;
        int            idx;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(p) + k) % N_CH;
            if (!found && r[OW'(idx)]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t        state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [TW-1:0]     turn_q, turn_d;

    logic [N_CH-1:0]   gnt_d;
    logic [OW-1:0]     owner_d;
    logic              bus_valid_d;
    logic [WIDTH-1:0]  bus_data_d;

    logic [OW-1:0]     pick;
    logic              other_req;
    logic              do_release;

    assign pick      = rr_pick(req, ptr_q);
    // gnt is one-hot on the owner, so masking it leaves only waiting channels.
    assign other_req = |(req & ~gnt);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d     = state_q;
        ptr_d       = ptr_q;
        burst_d     = burst_q;
        turn_d      = turn_q;
        gnt_d       = gnt;
        owner_d     = owner;
        bus_valid_d = 1'b0;
        bus_data_d  = bus_data;
        do_release  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d        = '0;
                    gnt_d[pick]  = 1'b1;
                    owner_d      = pick;
                    burst_d      = BW'(1);
                    state_d      = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (!req[owner]) begin
                    // Owner let go: nothing sampled on this edge.
                    do_release = 1'b1;
                end else begin
                    bus_valid_d = 1'b1;
                    bus_data_d  = bus_w;
                    if (burst_q == BURST_MAX) begin
                        // Burst cap only matters when someone else is waiting;
                        // a lone requester simply starts a fresh burst.
                        if (other_req) do_release = 1'b1;
                        else           burst_d    = BW'(1);
                    end else begin
                        burst_d = burst_q + BW'(1);
                    end
                end
            end

            ST_TURN: begin
                gnt_d = '0;
                if (turn_q == TURN_MAX) state_d = ST_IDLE;
                else                    turn_d  = turn_q + TW'(1);
            end

            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (do_release) begin
            gnt_d   = '0;
            ptr_d   = next_idx(owner);
            turn_d  = TW'(1);
            state_d = ST_TURN;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            burst_q   <= '0;
            turn_q    <= '0;
            gnt       <= '0;
            owner     <= '0;
            bus_valid <= 1'b0;
            bus_data  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            turn_q    <= turn_d;
            gnt       <= gnt_d;
            owner     <= owner_d;
            bus_valid <= bus_valid_d;
            bus_data  <= bus_data_d;
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//   Directed checks of the tristate bus arbiter (N_CH=4, WIDTH=8, MAX_BURST=4,
//   TURNAROUND=1) followed by a random-traffic invariant phase.
// -----------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

    localparam int N_CH       = 4;
    localparam int WIDTH      = 8;
    localparam int MAX_BURST  = 4;
    localparam int TURNAROUND = 1;

    logic                   clk;
    logic                   rst;
    logic [N_CH-1:0]        req;
    logic [N_CH*WIDTH-1:0]  din;
    logic [N_CH-1:0]        gnt;
    logic [1:0]             owner;
    logic                   bus_valid;
    logic [WIDTH-1:0]       bus_data;

    int n_assert = 0;
    int n_fail   = 0;

    tristate_bus_arbiter #(
        .N_CH       (N_CH),
        .WIDTH      (WIDTH),
        .MAX_BURST  (MAX_BURST),
        .TURNAROUND (TURNAROUND)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .owner     (owner),
        .bus_valid (bus_valid),
        .bus_data  (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [3:0]  t3_gnt   [13];
    logic        t3_valid [13];
    logic [7:0]  t3_data  [13];

    logic [N_CH*WIDTH-1:0] prev_din;
    logic [1:0]            prev_owner;
    logic [N_CH-1:0]       prev_gnt;

    initial begin
        // ---------------- 1: reset with all channels requesting ----------
        rst = 1'b1;
        req = 4'b1111;
        din = '0;
        tick();
        tick();
        check("rst_gnt",   gnt,       0);
        check("rst_valid", bus_valid, 0);
        check("rst_data",  bus_data,  8'h00);
        check("rst_owner", owner,     0);
        rst = 1'b0;
        tick();                               // IDLE, pointer 0 -> ch0
        check("post_rst_gnt",   gnt,   4'b0001);
        check("post_rst_owner", owner, 0);
        req = 4'b0000;
        tick();                               // owner dropped req -> TURN, ptr=1
        check("drop_gnt",   gnt,       0);
        check("drop_valid", bus_valid, 0);
        tick();                               // TURN -> IDLE

        // ---------------- 2: single channel 2, three words ----------------
        req = 4'b0100;
        din = 32'h44_A5_22_11;
        tick();                               // arbitration -> ch2
        check("t2_gnt",   gnt,       4'b0100);
        check("t2_owner", owner,     2);
        check("t2_valid0", bus_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_word_valid", bus_valid, 1);
            check("t2_word_data",  bus_data,  8'hA5);
            check("t2_word_gnt",   gnt,       4'b0100);
        end
        req = 4'b0000;
        tick();                               // release -> TURN, ptr=3
        check("t2_rel_gnt",   gnt,       0);
        check("t2_rel_valid", bus_valid, 0);
        check("t2_rel_data",  bus_data,  8'hA5);
        tick();                               // TURN -> IDLE
        check("t2_turn_gnt",   gnt,       0);
        check("t2_turn_valid", bus_valid, 0);

        // ---------------- 3: ch0 and ch1 compete, burst limit 4 ----------
        t3_gnt   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010,
                     4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0001};
        t3_valid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        t3_data  = '{8'hA5, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                     8'h21, 8'h21, 8'h21, 8'h21, 8'h21, 8'h21};
        req = 4'b0011;
        din = 32'h44_33_21_10;
        for (int i = 0; i < 13; i++) begin
            tick();
            check($sformatf("t3_gnt[%0d]", i),   gnt,       t3_gnt[i]);
            check($sformatf("t3_valid[%0d]", i), bus_valid, t3_valid[i]);
            check($sformatf("t3_data[%0d]", i),  bus_data,  t3_data[i]);
        end
        check("t3_wrap_owner", owner, 0);

        // ---------------- 4: lone requester keeps the bus ------------------
        req = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            din[7:0] = 8'h50 + 8'(i);
            tick();
            check($sformatf("t4_gnt[%0d]", i),   gnt,       4'b0001);
            check($sformatf("t4_valid[%0d]", i), bus_valid, 1);
            check($sformatf("t4_data[%0d]", i),  bus_data,  8'h50 + 8'(i));
        end

        // ---------------- 5: reset in the middle of a ch3 burst -----------
        req = 4'b1000;
        din[31:24] = 8'h3C;
        tick();                               // ch0 drops -> TURN, ptr=1
        check("t5_rel_gnt",  gnt,      0);
        check("t5_rel_data", bus_data, 8'h59);
        tick();                               // TURN -> IDLE
        tick();                               // arbitration from 1 -> ch3
        check("t5_gnt",   gnt,   4'b1000);
        check("t5_owner", owner, 3);
        tick();
        check("t5_valid", bus_valid, 1);
        check("t5_data",  bus_data,  8'h3C);
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_gnt",   gnt,       0);
        check("t5_rst_valid", bus_valid, 0);
        check("t5_rst_data",  bus_data,  8'h00);
        check("t5_rst_owner", owner,     0);
        rst = 1'b0;
        req = 4'b1111;
        tick();                               // pointer back at 0 -> ch0
        check("t5_ptr_gnt", gnt, 4'b0001);

        // ---------------- 6: random traffic invariants --------------------
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            din        = $urandom;
            prev_din   = din;
            prev_owner = owner;
            prev_gnt   = gnt;
            tick();
            check("rand_onehot0", 32'($onehot0(gnt)), 1);
            if (bus_valid) begin
                check("rand_known",     32'($isunknown(bus_data)), 0);
                check("rand_prev_gnt",  prev_gnt, 4'b0001 << prev_owner);
                check("rand_data",      bus_data, prev_din[prev_owner*WIDTH +: WIDTH]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
